// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//
// EX-stage front end for the iterative divider. It accepts a DIV/DIVU from
// EX, latches operands and signedness, runs the divider start/annul
// handshake, stalls the pipeline until the result comes back and then
// presents {HI,LO} with a one-cycle write strobe.
//
// Configuration macro:
//   DIV_ZERO_FAST_EN - when defined, a request with a zero divisor skips the
//                      divider entirely and completes with {0,0} after one
//                      stall cycle. When undefined, divide-by-zero goes
//                      through the divider like any other operand pair.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   div_req_i        EX holds a DIV/DIVU (stable while stall_o=1)
//   signed_i         1=DIV, 0=DIVU
//   opdata1_i/2_i    dividend / divisor
//   flush_i          pipeline flush (exception / branch kill)
//   stall_o          stall request to the pipeline controller
//   hi_o / lo_o      remainder / quotient, qualified by hilo_we_o
//   hilo_we_o        one-cycle HI/LO write strobe
//   div_start_o      divider start
//   div_annul_o      divider annul
//   div_signed_o     divider signed select
//   div_opdata1_o/2_o operands to the divider
//   div_result_i     divider result {remainder, quotient}
//   div_ready_i      divider result valid
//   dbg_state_o      current FSM state (0 IDLE, 1 BUSY, 2 DONE, 3 ABORT)
//
// Handshake: the request is held on div_req_i for as long as stall_o=1; the
// pipeline advances on the first edge where stall_o=0 (the DONE cycle). On
// the divider side, start stays high from acceptance until the result is
// taken, and dropping start is what releases the divider from its end state.
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int WIDTH        = 32,
    parameter int ABORT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_req_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o,
    output logic               hilo_we_o,
    output logic               div_start_o,
    output logic               div_annul_o,
    output logic               div_signed_o,
    output logic [WIDTH-1:0]   div_opdata1_o,
    output logic [WIDTH-1:0]   div_opdata2_o,
    input  logic [2*WIDTH-1:0] div_result_i,
    input  logic               div_ready_i,
    output logic [1:0]         dbg_state_o
);

    localparam int CNT_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ABORT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   op1_q;
    logic [WIDTH-1:0]   op2_q;
    logic               sign_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               hilo_we_q;
    logic               annul_q;

    logic               in_idle;
    logic               in_busy;
    logic               accept;
    logic               zero_fast;

    assign in_idle = (state_q == S_IDLE);
    assign in_busy = (state_q == S_BUSY);

    // The IDLE pass-through paths are combinational from the inputs, so they
    // are gated with rst to keep every output at 0 while reset is asserted.
    assign accept = in_idle & div_req_i & ~flush_i & ~rst;

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = accept & (opdata2_i == '0);
`else
    assign zero_fast = 1'b0;
`endif

    assign div_start_o = (accept & ~zero_fast) | in_busy;
    assign stall_o     = accept | in_busy;

    // In IDLE the divider sees the request operands directly so it can start
    // in the acceptance cycle; afterwards it must see the latched copies,
    // since signedness is sampled again at the final correction step.
    assign div_signed_o  = in_idle ? (signed_i & ~rst)          : sign_q;
    assign div_opdata1_o = in_idle ? (rst ? '0 : opdata1_i)     : op1_q;
    assign div_opdata2_o = in_idle ? (rst ? '0 : opdata2_i)     : op2_q;

    // A flush landing on the DONE cycle kills the write but not the return
    // to IDLE.
    assign hilo_we_o   = hilo_we_q & ~flush_i;
    assign div_annul_o = annul_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op1_q     <= '0;
            op2_q     <= '0;
            sign_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            hilo_we_q <= 1'b0;
            annul_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    hilo_we_q <= 1'b0;
                    annul_q   <= 1'b0;
                    if (accept) begin
                        op1_q  <= opdata1_i;
                        op2_q  <= opdata2_i;
                        sign_q <= signed_i;
                        if (zero_fast) begin
                            hi_q      <= '0;
                            lo_q      <= '0;
                            hilo_we_q <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            state_q   <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    // Flush wins over a same-cycle ready: the result is dropped.
                    if (flush_i) begin
                        annul_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_ABORT;
                    end else if (div_ready_i) begin
                        hi_q      <= div_result_i[2*WIDTH-1:WIDTH];
                        lo_q      <= div_result_i[WIDTH-1:0];
                        hilo_we_q <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    hilo_we_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                S_ABORT: begin
                    // start low + annul high for a fixed number of cycles
                    // lets both a computing divider and one parked in its
                    // divide-by-zero/end state fall back to free.
                    if (cnt_q == CNT_LAST) begin
                        annul_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_issue_ctrl
//
// Bench for div_issue_ctrl. A behavioural iterative divider sits on the
// divider side: LAT cycles from start to ready, holds its result in an end
// state until start drops, obeys annul only while computing, and sends a
// zero divisor straight to its end state with {0,0}. Expected {HI,LO} values
// are pushed into exp_q when a request is driven and popped whenever the
// controller strobes hilo_we_o.
// ---------------------------------------------------------------------------
module tb_div_issue_ctrl;

    localparam int W   = 32;
    localparam int LAT = 34;

    logic           clk = 1'b0;
    logic           rst;
    logic           div_req_i;
    logic           signed_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           flush_i;
    logic           stall_o;
    logic [W-1:0]   hi_o;
    logic [W-1:0]   lo_o;
    logic           hilo_we_o;
    logic           div_start_o;
    logic           div_annul_o;
    logic           div_signed_o;
    logic [W-1:0]   div_opdata1_o;
    logic [W-1:0]   div_opdata2_o;
    logic [2*W-1:0] div_result_i;
    logic           div_ready_i;
    logic [1:0]     dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*W-1:0] exp_q[$];

    div_issue_ctrl #(.WIDTH(W), .ABORT_CYCLES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .div_req_i     (div_req_i),
        .signed_i      (signed_i),
        .opdata1_i     (opdata1_i),
        .opdata2_i     (opdata2_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .hilo_we_o     (hilo_we_o),
        .div_start_o   (div_start_o),
        .div_annul_o   (div_annul_o),
        .div_signed_o  (div_signed_o),
        .div_opdata1_o (div_opdata1_o),
        .div_opdata2_o (div_opdata2_o),
        .div_result_i  (div_result_i),
        .div_ready_i   (div_ready_i),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // ---------------- divider model ----------------
    logic [1:0]  dv_st;   // 0 free, 1 computing, 2 end
    int          dv_cnt;
    logic [63:0] dv_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_st  <= 2'd0;
            dv_cnt <= 0;
            dv_res <= 64'd0;
        end else begin
            case (dv_st)
                2'd0: if (div_start_o && !div_annul_o) begin
                    if (div_opdata2_o == 32'd0) begin
                        dv_res <= 64'd0;
                        dv_st  <= 2'd2;
                    end else begin
                        dv_cnt <= 1;
                        dv_st  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (div_annul_o || !div_start_o) begin
                        dv_st <= 2'd0;
                    end else if (dv_cnt == LAT - 1) begin
                        // signedness and operands are read at the end, as
                        // the real divider does at final correction
                        dv_res <= ref_div(div_signed_o, div_opdata1_o, div_opdata2_o);
                        dv_st  <= 2'd2;
                    end else begin
                        dv_cnt <= dv_cnt + 1;
                    end
                end
                default: if (!div_start_o) dv_st <= 2'd0;
            endcase
        end
    end

    assign div_result_i = dv_res;
    assign div_ready_i  = (dv_st == 2'd2);

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && hilo_we_o) begin
            if (exp_q.size() == 0)
                check_eq("unexpected_we", 64'(hilo_we_o), 64'd0);
            else
                check_eq("hilo", {hi_o, lo_o}, exp_q.pop_front());
        end
    end

    // ---------------- driver ----------------
    // Entered just after a rising edge. Holds the request until the DONE
    // cycle (stall_o low), returns the number of stall cycles in lat.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit tog, input bit chk_start,
                          input logic exp_start, output int lat);
        int  n;
        bit  done;
        exp_q.push_back(exp);
        div_req_i = 1'b1;
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        n    = 0;
        done = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (n == 0 && chk_start) check_eq("start_first_cycle", 64'(div_start_o), 64'(exp_start));
            if (!stall_o) begin
                done = 1;
            end else begin
                n++;
                @(posedge clk);
                #1;
                if (tog) signed_i = ~s;
            end
        end
        lat = n;
        if (!done) begin
            check_eq("done_timeout", 64'(stall_o), 64'd0);
        end else begin
            check_eq("start_in_done", 64'(div_start_o), 64'd0);
            check_eq("we_in_done", 64'(hilo_we_o), 64'd1);
        end
        @(posedge clk);
        #1;
        div_req_i = 1'b0;
        signed_i  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          lat;
        int          n_annul;
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;

        rst       = 1'b1;
        div_req_i = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        flush_i   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", 64'(stall_o), 64'd0);
        check_eq("rst_we", 64'(hilo_we_o), 64'd0);
        check_eq("rst_start", 64'(div_start_o), 64'd0);
        check_eq("rst_annul", 64'(div_annul_o), 64'd0);
        check_eq("rst_hilo", {hi_o, lo_o}, 64'd0);
        check_eq("rst_state", 64'(dbg_state_o), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // DIVU 100/7, with latency = divider latency + 1
        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b1, 1'b1, lat);
        check_eq("latency_100_7", 64'(lat), 64'(LAT + 1));

        // DIV -7/2, signed_i toggled after acceptance
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1, 1'b0, 1'b0, lat);

        // back-to-back: second start on the cycle after the first DONE
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b0, 1'b0, 1'b0, lat);
        do_div(1'b0, 32'h8000_0000, 32'h10, {32'd0, 32'h0800_0000}, 1'b0, 1'b1, 1'b1, lat);

        // flush in the middle of BUSY
        div_req_i = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        check_eq("busy_before_flush", 64'(dbg_state_o), 64'd1);
        flush_i   = 1'b1;
        div_req_i = 1'b0;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        n_annul = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (div_annul_o) n_annul++;
            if (i == 0) begin
                check_eq("abort_stall", 64'(stall_o), 64'd0);
                check_eq("abort_start", 64'(div_start_o), 64'd0);
            end
        end
        check_eq("annul_cycles", 64'(n_annul), 64'd2);
        check_eq("idle_after_abort", 64'(dbg_state_o), 64'd0);
        check_eq("divider_free_after_abort", 64'(dv_st), 64'd0);
        @(posedge clk);
        #1;
        do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 1'b1, 1'b1, lat);

        // divide by zero, flushed one cycle after acceptance
        div_req_i = 1'b1;
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        @(posedge clk);
        #1;
        flush_i   = 1'b1;
        div_req_i = 1'b0;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("idle_after_zero_flush", 64'(dbg_state_o), 64'd0);
        check_eq("divider_free_after_zero_flush", 64'(dv_st), 64'd0);
        @(posedge clk);
        #1;
        do_div(1'b0, 32'd8, 32'd2, {32'd0, 32'd4}, 1'b0, 1'b0, 1'b0, lat);

        // divide by zero, not flushed
`ifdef DIV_ZERO_FAST_EN
        do_div(1'b0, 32'd5, 32'd0, 64'd0, 1'b0, 1'b1, 1'b0, lat);
        check_eq("zero_fast_latency", 64'(lat), 64'd1);
`else
        do_div(1'b0, 32'd5, 32'd0, 64'd0, 1'b0, 1'b1, 1'b1, lat);
        check_eq("zero_latency", 64'(lat), 64'd2);
`endif

        // asynchronous reset while BUSY, request still held
        div_req_i = 1'b1;
        signed_i  = 1'b1;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd7;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_state", 64'(dbg_state_o), 64'd0);
        check_eq("arst_stall", 64'(stall_o), 64'd0);
        check_eq("arst_start", 64'(div_start_o), 64'd0);
        check_eq("arst_annul", 64'(div_annul_o), 64'd0);
        check_eq("arst_we", 64'(hilo_we_o), 64'd0);
        check_eq("arst_signed", 64'(div_signed_o), 64'd0);
        check_eq("arst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
        check_eq("arst_hilo", {hi_o, lo_o}, 64'd0);
        div_req_i = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_div(1'b0, 32'd21, 32'd4, {32'd1, 32'd5}, 1'b0, 1'b1, 1'b1, lat);
        check_eq("latency_21_4", 64'(lat), 64'(LAT + 1));

        // random operand pairs, both signednesses
        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = 32'($urandom_range(1, 1000));
            do_div(rs, ra, rb, ref_div(rs, ra, rb), 1'b0, 1'b0, 1'b0, lat);
        end

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- EX-stage controller sitting directly upstream of the iterative 32-bit divider.
- Accepts DIV/DIVU requests from the EX stage, latches operands and signedness, and drives the divider's start/annul handshake.
- Holds the pipeline stalled until the result arrives, then presents {HI,LO} with a one-cycle write enable to the HI/LO register file.
- Handles pipeline flush mid-operation, including divisor-zero operations already in flight.

Parameters:
- WIDTH, 32, operand width; the divider result is 2*WIDTH.
- ABORT_CYCLES, 2, cycles start stays low and annul stays high after a flush, so the divider always returns to its free state.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- div_req_i  in  1  EX holds a DIV/DIVU; held stable while stall_o=1
- signed_i  in  1  1=DIV, 0=DIVU
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- flush_i  in  1  pipeline flush (exception/branch kill)
- stall_o  out  1  stall request to the pipeline controller
- hi_o  out  WIDTH  remainder
- lo_o  out  WIDTH  quotient
- hilo_we_o  out  1  one-cycle HI/LO write strobe
- div_start_o  out  1  to divider start
- div_annul_o  out  1  to divider annul
- div_signed_o  out  1  to divider signed select
- div_opdata1_o  out  WIDTH  to divider
- div_opdata2_o  out  WIDTH  to divider
- div_result_i  in  2*WIDTH  from divider: {remainder, quotient}
- div_ready_i  in  1  from divider

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; operand, sign and result registers cleared.
- IDLE:
  - div_start_o = div_req_i & ~flush_i (combinational).
  - div_opdata*/div_signed_o driven straight from the inputs.
  - stall_o = div_req_i & ~flush_i.
  - On an accepted request: latch op1, op2, signed; go to BUSY.
- BUSY:
  - div_start_o=1. div_signed_o and div_opdata*_o come from the latched registers; they must stay stable because the divider reads signedness again at final correction.
  - stall_o=1.
  - flush_i=1 -> ABORT; flush has priority over div_ready_i in the same cycle.
  - Else if div_ready_i=1: register div_result_i into the hi/lo registers; go to DONE.
- DONE (exactly one cycle):
  - div_start_o=0, which releases the divider from its end state; stall_o=0; hilo_we_o=1; hi_o/lo_o valid.
  - The pipeline advances on this edge. Next state is IDLE, so a back-to-back DIV can start on the following cycle; the divider is free by then.
  - flush_i in DONE suppresses hilo_we_o and still returns to IDLE.
- ABORT:
  - div_start_o=0, div_annul_o=1, stall_o=0, hilo_we_o=0.
  - Counter runs ABORT_CYCLES cycles, then IDLE. New requests are ignored until then.
  - This covers the divide-by-zero path, which ignores annul and must pass through its end state.
- div_annul_o is 0 in every state except ABORT.
- hi_o/lo_o hold their last captured value outside DONE. Only hilo_we_o qualifies them.
- Latency: from the start cycle in IDLE to DONE = divider latency + 1 cycle (one capture register).
- Divide by zero is not trapped: it issues normally and the divider returns {0,0}.
- Reset mid-operation returns to IDLE immediately. The divider shares rst, so both sides resynchronise.

Optional Feature:
- DIV_ZERO_FAST_EN defined:
  - In IDLE, a request with opdata2_i==0 does not assert div_start_o.
  - FSM goes straight to DONE with hi/lo = 0, giving one stall cycle.
- Undefined: divide-by-zero goes through the divider like any other operand pair.

Test Plan:
- DIVU 100/7 -> one hilo_we_o pulse, lo_o=14, hi_o=2; stall_o deasserts in the DONE cycle; div_start_o falls in DONE.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. Toggle signed_i on the input after acceptance -> result unchanged, because the latched sign is used.
- DIVU 0xFFFFFFFF/1 immediately followed by DIVU 0x80000000/0x10 -> results {0,0xFFFFFFFF} then {0,0x08000000}; second start one cycle after the first DONE.
- flush_i 10 cycles into BUSY -> div_annul_o=1 for 2 cycles, no hilo_we_o; next DIVU 9/3 -> lo=3, hi=0.
- DIVU 5/0 then flush_i 1 cycle later -> no write, controller and divider both idle after ABORT; following DIVU 8/2 -> lo=4, hi=0. With DIV_ZERO_FAST_EN and no flush: 5/0 -> no div_start_o, hilo_we_o one cycle later with {0,0}.
- Assert rst in BUSY -> all outputs 0 asynchronously; after release, DIVU 21/4 -> lo=5, hi=1.
